// File: rtl/mem_burst_master.sv
// mem_burst_master: burst transaction engine in front of a single-port valid/ready memory.
// Takes one burst command at a time and issues one memory beat per handshake. Write beats
// come from a valid/ready source and read beats go to a valid/ready sink.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   cmd_valid/ready/wr/addr/len burst command (len 0..DEPTH beats)
//   wd_valid/ready/data         write-data source
//   rd_valid/ready/data         read-data sink
//   mem_valid/wr_rd/addr/wdata  request to memory
//   mem_rdata, mem_ready        response from memory
//   busy                        high outside IDLE
//   done                        one-cycle pulse when a burst completes
//
// Every output is a register or a decode of the state register. No input reaches an output
// combinationally.
module mem_burst_master #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [WIDTH-1:0]      wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrReq,
        StRdReq,
        StRdHold,
        StDone
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LenOne   = (ADDR_WIDTH + 1)'(1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic                  rd_valid_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Explicit wrap so a non-power-of-two DEPTH still cycles through DEPTH locations.
    assign addr_next = (cur_addr_q == AddrLast) ? '0 : cur_addr_q + AddrOne;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cur_addr_q  <= cmd_addr;
                        remaining_q <= cmd_len;
                        if (cmd_len == '0) begin
                            state_q <= StDone;
                        end else if (cmd_wr) begin
                            state_q <= StWrData;
                        end else begin
                            // Read request is raised on entry so RD_REQ presents it at once.
                            state_q     <= StRdReq;
                            mem_valid_q <= 1'b1;
                            mem_wr_rd_q <= 1'b0;
                            mem_addr_q  <= cmd_addr;
                        end
                    end
                end
                StWrData: begin
                    if (wd_valid) begin
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= 1'b1;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= wd_data;
                        state_q     <= StWrReq;
                    end
                end
                StWrReq: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        cur_addr_q  <= addr_next;
                        remaining_q <= remaining_q - LenOne;
                        state_q     <= (remaining_q == LenOne) ? StDone : StWrData;
                    end
                end
                StRdReq: begin
                    if (mem_ready) begin
                        rd_data_q   <= mem_rdata;
                        rd_valid_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        cur_addr_q  <= addr_next;
                        remaining_q <= remaining_q - LenOne;
                        state_q     <= StRdHold;
                    end
                end
                StRdHold: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (remaining_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q     <= StRdReq;
                            mem_valid_q <= 1'b1;
                            mem_wr_rd_q <= 1'b0;
                            mem_addr_q  <= cur_addr_q;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign wd_ready  = (state_q == StWrData);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign mem_valid = mem_valid_q;
    assign mem_wr_rd = mem_wr_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed and randomized bursts against mem_burst_master, with a
// behavioural memory (random ready stalls) and a command-level model of memory contents.
module tb_mem_burst_master;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LW    = AW + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_wr = 1'b0;
    logic [AW-1:0]    cmd_addr = '0;
    logic [AW:0]      cmd_len = '0;
    logic             wd_valid = 1'b0;
    logic             wd_ready;
    logic [WIDTH-1:0] wd_data = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             mem_valid;
    logic             mem_wr_rd;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready = 1'b0;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    mem_burst_master #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wd_data  (wd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .mem_valid(mem_valid),
        .mem_wr_rd(mem_wr_rd),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .done     (done)
    );

    // Memory seen by the DUT, and the contents expected from the commands issued.
    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] exp_mem [DEPTH];
    logic [WIDTH-1:0] wq      [DEPTH];
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc, done_cyc;
    int acc_cnt, done_cnt, wd_cnt;
    int hs_wr[$], hs_addr[$], hs_data[$], rd_got[$];
    int stall_cnt = 0, stall_tgt = 0, stall_fixed = -1;
    bit in_burst = 1'b0;

    logic             p_ok = 1'b0, p_mv, p_mhs, p_wr, p_rv, p_rhs, p_done;
    logic [AW-1:0]    p_addr;
    logic [WIDTH-1:0] p_wdata, p_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs at the negedge: everything seen here holds through the next posedge.
    task automatic monitor();
        if (rst !== 1'b1) begin
            in_burst  = 1'b0;
            stall_cnt = 0;
        end else begin
            if (p_ok) begin
                if (p_mv && !p_mhs)
                    check("mem_hold", {mem_valid, mem_wr_rd, mem_addr, mem_wdata},
                          {1'b1, p_wr, p_addr, p_wdata});
                if (p_rv && !p_rhs)
                    check("rd_hold", {rd_valid, rd_data}, {1'b1, p_rd});
                if (p_done)
                    check("done_pulse", {done, busy, cmd_ready}, 3'b001);
            end
            check("busy", busy, in_burst);
            check("cmd_ready", cmd_ready, !in_burst);
            check("no_mem_in_wait", mem_valid && (rd_valid || wd_ready), 1'b0);
            if (cmd_valid && cmd_ready) begin
                acc_cnt++;
                acc_cyc  = cyc;
                in_burst = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_burst = 1'b0;
            end
            if (wd_valid && wd_ready) wd_cnt++;
            if (rd_valid && rd_ready) rd_got.push_back(int'(rd_data));
            if (mem_valid && mem_ready) begin
                hs_wr.push_back(int'(mem_wr_rd));
                hs_addr.push_back(int'(mem_addr));
                hs_data.push_back(int'(mem_wdata));
                if (mem_wr_rd) mem[mem_addr] = mem_wdata;
                stall_cnt = 0;
                stall_tgt = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(2));
            end else if (mem_valid) begin
                stall_cnt++;
            end
        end
        p_ok    = (rst === 1'b1);
        p_mv    = mem_valid;
        p_mhs   = mem_valid && mem_ready;
        p_wr    = mem_wr_rd;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_rv    = rd_valid;
        p_rhs   = rd_valid && rd_ready;
        p_rd    = rd_data;
        p_done  = done;
        cyc++;
    endtask

    // One clock: observe at negedge, then the memory drives ready just after the posedge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (mem_valid === 1'b1) mem_ready = (stall_cnt >= stall_tgt);
        else mem_ready = 1'($urandom_range(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {mem_valid, mem_wr_rd, mem_addr, mem_wdata, rd_valid, rd_data,
                    done, busy, wd_ready, cmd_ready}, 32'h1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) wq[i] = WIDTH'($urandom);
    endtask

    task automatic burst(input bit wr, input int addr, input int len, input int gap_pct,
                         input int sink_pct, input int hold);
        int n;
        int start;
        int hold_left;
        n = 0;
        hold_left = hold;
        hs_wr.delete(); hs_addr.delete(); hs_data.delete(); rd_got.delete();
        acc_cnt = 0; done_cnt = 0; wd_cnt = 0; acc_cyc = -1; done_cyc = -1;
        start     = cyc;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        while (done_cnt == 0 && n < 3000) begin
            wd_valid = wr && (wd_cnt < len) && (int'($urandom_range(99)) >= gap_pct);
            wd_data  = wd_valid ? wq[wd_cnt % DEPTH] : WIDTH'($urandom);
            if (hold_left > 0 && rd_valid === 1'b1) begin
                rd_ready = 1'b0;
                hold_left--;
            end else begin
                rd_ready = (int'($urandom_range(99)) >= sink_pct);
            end
            step();
            if (acc_cnt != 0) cmd_valid = 1'b0;
            n++;
        end
        check("burst_timeout", done_cnt != 0, 1'b1);
        cmd_valid = 1'b0;
        wd_valid  = 1'b0;
        rd_ready  = 1'b0;
        step();
        check("done_count", done_cnt, 1);
        check("accept_cycle", acc_cyc, start);
        if (len == 0) check("len0_done_latency", done_cyc, acc_cyc + 1);
        check("hs_count", hs_addr.size(), len);
        for (int i = 0; i < len && i < hs_addr.size(); i++) begin
            check("hs_addr", hs_addr[i], (addr + i) % DEPTH);
            check("hs_wr", hs_wr[i], int'(wr));
            if (wr) check("hs_wdata", hs_data[i], wq[i]);
        end
        if (wr) begin
            check("wd_beats", wd_cnt, len);
            for (int i = 0; i < len; i++) exp_mem[(addr + i) % DEPTH] = wq[i];
        end else begin
            check("rd_beats", rd_got.size(), len);
            for (int i = 0; i < len && i < rd_got.size(); i++)
                check("rd_data", rd_got[i], exp_mem[(addr + i) % DEPTH]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = WIDTH'($urandom);
            exp_mem[i] = mem[i];
        end

        // Reset held for two cycles.
        rst = 1'b0;
        step();
        step();
        check_reset_vals("reset_vals");
        rst = 1'b1;

        // Single-beat write.
        wq[0] = 8'hA5;
        burst(1'b1, 15, 1, 0, 0, 0);
        check("bd_mem15", mem[15], 8'hA5);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Five-beat write then read back.
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44; wq[4] = 8'h55;
        burst(1'b1, 16, 5, 0, 0, 0);
        burst(1'b0, 16, 5, 0, 0, 0);
        if (rd_got.size() == 5) begin
            check("rd_first", rd_got[0], 8'h11);
            check("rd_last", rd_got[4], 8'h55);
        end

        // Address wrap.
        fill_random();
        burst(1'b1, 30, 4, 0, 0, 0);
        burst(1'b0, 30, 4, 0, 0, 0);

        // Sink backpressure and source gaps.
        burst(1'b0, 16, 3, 0, 0, 4);
        fill_random();
        burst(1'b1, 5, 6, 50, 0, 0);

        // Zero-length commands and a full-depth burst with fixed memory stalls.
        burst(1'b1, 7, 0, 0, 0, 0);
        burst(1'b0, 9, 0, 0, 0, 0);
        stall_fixed = 2;
        stall_tgt   = 2;
        fill_random();
        burst(1'b1, 0, 32, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) check("bd_full", mem[i], exp_mem[i]);
        stall_fixed = -1;

        // Reset after the third write handshake of an 8-beat burst.
        fill_random();
        hs_wr.delete(); hs_addr.delete(); hs_data.delete();
        acc_cnt = 0; done_cnt = 0; wd_cnt = 0;
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = '0; cmd_len = LW'(8);
        n = 0;
        while (hs_addr.size() < 3 && n < 500) begin
            wd_valid = (wd_cnt < 8);
            wd_data  = wq[wd_cnt % DEPTH];
            step();
            if (acc_cnt != 0) cmd_valid = 1'b0;
            n++;
        end
        check("reset_hs3_reached", hs_addr.size(), 3);
        for (int i = 0; i < 3 && i < hs_data.size(); i++) begin
            check("rst_hs_addr", hs_addr[i], i);
            check("rst_hs_wdata", hs_data[i], wq[i]);
            exp_mem[i] = wq[i];
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        wd_valid  = 1'b1;
        step();
        check_reset_vals("reset_mid_burst");
        wd_valid = 1'b0;
        rst      = 1'b1;
        burst(1'b0, 0, 8, 0, 0, 0);

        // Randomized bursts.
        for (int k = 0; k < 20; k++) begin
            fill_random();
            burst(1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)),
                  int'($urandom_range(DEPTH)), int'($urandom_range(60)),
                  int'($urandom_range(60)), int'($urandom_range(3)));
        end

        for (int i = 0; i < DEPTH; i++) check("bd_final", mem[i], exp_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
